// File: rtl/cavlc_scan_ctrl_if.sv
// Block/statistics bus of the CAVLC residual-block scan controller.
//   slave  : controller side (cavlc_scan_ctrl)
//   master : producer/consumer side (block source, run-before counter, bitstream writer)
// Signals:
//   in_valid_i/in_ready_o, coeffs_i, blk_len_i      block input handshake and payload
//   cnt_rst_o, start_cnt_o, coeff_o                  run-before counter control
//   out_valid_o/out_ready_i, total_coeff_o,
//   trailing_ones_o, t1_signs_o, total_zeros_o       block statistics handshake
interface cavlc_scan_ctrl_if #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CW      = 8
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [MAX_LEN*CW-1:0]   coeffs_i;
  logic [4:0]              blk_len_i;
  logic                    cnt_rst_o;
  logic                    start_cnt_o;
  logic [CW-1:0]           coeff_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [4:0]              total_coeff_o;
  logic [1:0]              trailing_ones_o;
  logic [2:0]              t1_signs_o;
  logic [4:0]              total_zeros_o;

  modport slave (
    input  in_valid_i, coeffs_i, blk_len_i, out_ready_i,
    output in_ready_o, cnt_rst_o, start_cnt_o, coeff_o, out_valid_o,
           total_coeff_o, trailing_ones_o, t1_signs_o, total_zeros_o
  );

  modport master (
    output in_valid_i, coeffs_i, blk_len_i, out_ready_i,
    input  in_ready_o, cnt_rst_o, start_cnt_o, coeff_o, out_valid_o,
           total_coeff_o, trailing_ones_o, t1_signs_o, total_zeros_o
  );
endinterface

// File: rtl/cavlc_scan_ctrl.sv
// Sequencer for one CAVLC residual block.
// Latches a zigzag-ordered block, pulses cnt_rst_o to clear the run-before
// counter, then streams the coefficients highest-frequency first on
// start_cnt_o/coeff_o while accumulating TotalCoeff, TrailingOnes, the
// trailing-one signs and TotalZeros, and finally offers those statistics on
// a valid/ready handshake.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  cavlc_scan_ctrl_if.slave (block input, counter control, statistics)
module cavlc_scan_ctrl #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cavlc_scan_ctrl_if.slave     bus
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     len_m1_q;
  logic [CW-1:0]        coeff_q [MAX_LEN];
  logic [4:0]           tc_q;
  logic [1:0]           t1_q;
  logic [2:0]           sg_q;
  logic [4:0]           tz_q;
  logic                 seen_q;     // a nonzero has been streamed in this block
  logic                 t1_open_q;  // trailing-one run still extendable

  // Coefficient currently addressed by the scan index and its classification
  logic [CW-1:0]        cur_c;
  logic                 c_nz;
  logic                 c_one;
  logic [IDX_W-1:0]     eff_len_m1;

  assign cur_c = coeff_q[idx_q];
  assign c_nz  = (cur_c != '0);
  assign c_one = (cur_c == CW'(1)) || (cur_c == {CW{1'b1}});

  // Out-of-range block lengths (0 or above MAX_LEN) scan the full block
  always_comb begin
    eff_len_m1 = IDX_W'(MAX_LEN - 1);
    if ((bus.blk_len_i != 5'd0) && (32'(bus.blk_len_i) <= MAX_LEN)) begin
      eff_len_m1 = IDX_W'(bus.blk_len_i - 5'd1);
    end
  end

  // Control and statistics sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_m1_q  <= '0;
      tc_q      <= '0;
      t1_q      <= '0;
      sg_q      <= '0;
      tz_q      <= '0;
      seen_q    <= 1'b0;
      t1_open_q <= 1'b0;
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        coeff_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            for (int k = 0; k < int'(MAX_LEN); k++) begin
              coeff_q[k] <= bus.coeffs_i[k*CW +: CW];
            end
            len_m1_q <= eff_len_m1;
            state_q  <= CLR;
          end
        end
        CLR: begin
          tc_q      <= '0;
          t1_q      <= '0;
          sg_q      <= '0;
          tz_q      <= '0;
          seen_q    <= 1'b0;
          t1_open_q <= 1'b1;
          idx_q     <= len_m1_q;
          state_q   <= SCAN;
        end
        SCAN: begin
          if (c_nz) begin
            tc_q   <= tc_q + 5'd1;
            seen_q <= 1'b1;
          end else if (seen_q) begin
            tz_q <= tz_q + 5'd1;
          end
          // The run closes on the first non-unit nonzero or at the third one
          if (t1_open_q && c_nz) begin
            if (c_one) begin
              t1_q       <= t1_q + 2'd1;
              sg_q[t1_q] <= cur_c[CW-1];
              if (t1_q == 2'd2) begin
                t1_open_q <= 1'b0;
              end
            end else begin
              t1_open_q <= 1'b0;
            end
          end
          if (idx_q == '0) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and counter strobes decode straight from the state register
  assign bus.in_ready_o      = (state_q == IDLE);
  assign bus.cnt_rst_o       = (state_q == CLR);
  assign bus.out_valid_o     = (state_q == DONE);
  assign bus.start_cnt_o     = (state_q == SCAN);
  assign bus.coeff_o         = (state_q == SCAN) ? cur_c : '0;
  assign bus.total_coeff_o   = tc_q;
  assign bus.trailing_ones_o = t1_q;
  assign bus.t1_signs_o      = sg_q;
  assign bus.total_zeros_o   = tz_q;

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Self-checking bench for cavlc_scan_ctrl: directed blocks followed by
// random blocks, checked cycle by cycle against a block-level reference model.
module tb_cavlc_scan_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CW      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cavlc_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .CW(CW)) bus ();

  cavlc_scan_ctrl #(.MAX_LEN(MAX_LEN), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [7:0] blk [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Block statistics from the definitions: count nonzeros, find the highest
  // nonzero position, count zeros below it, then read the run of +-1 values
  // among the nonzeros starting from the highest frequency.
  function automatic void model(input int len, output int tc, output int t1,
                                output int sg, output int tz);
    int hi;
    int q[$];
    hi = -1;
    tc = 0; t1 = 0; sg = 0; tz = 0;
    for (int k = 0; k < len; k++) begin
      if (blk[k] != 0) begin
        tc++;
        hi = k;
        q.push_front(int'(blk[k]));
      end
    end
    for (int k = 0; k < hi; k++) begin
      if (blk[k] == 0) tz++;
    end
    foreach (q[i]) begin
      if (t1 == 3 || (q[i] != 1 && q[i] != -1)) break;
      if (q[i] < 0) sg = sg | (1 << t1);
      t1++;
    end
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready_o), 1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid_o), 0);
    chk({tag, "_cnt_rst"},   32'(bus.cnt_rst_o), 0);
    chk({tag, "_start_cnt"}, 32'(bus.start_cnt_o), 0);
    chk({tag, "_coeff"},     32'(bus.coeff_o), 0);
  endtask

  // Runs one block: accept, CLR, L scan cycles, DONE with bp cycles of
  // backpressure, handshake. abort_at >= 0 asserts rst in that scan cycle.
  task automatic run_block(input logic [4:0] blen, input int bp, input int abort_at);
    int len, e_tc, e_t1, e_sg, e_tz, w;
    len = (blen == 5'd0 || int'(blen) > 16) ? 16 : int'(blen);
    model(len, e_tc, e_t1, e_sg, e_tz);

    w = 0;
    while (!bus.in_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 32'(bus.in_ready_o), 1);

    for (int k = 0; k < 16; k++) bus.coeffs_i[k*8 +: 8] = blk[k];
    bus.blk_len_i  = blen;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.coeffs_i   = {$urandom, $urandom, $urandom, $urandom};
    chk("clr_cnt_rst", 32'(bus.cnt_rst_o), 1);
    chk("clr_start",   32'(bus.start_cnt_o), 0);
    chk("clr_ready",   32'(bus.in_ready_o), 0);

    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("scan_start",   32'(bus.start_cnt_o), 1);
      chk("scan_coeff",   32'(bus.coeff_o), {24'd0, blk[len-1-k]});
      chk("scan_valid",   32'(bus.out_valid_o), 0);
      chk("scan_cnt_rst", 32'(bus.cnt_rst_o), 0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("abort");
        chk("abort_tc", 32'(bus.total_coeff_o), 0);
        chk("abort_t1", 32'(bus.trailing_ones_o), 0);
        chk("abort_sg", 32'(bus.t1_signs_o), 0);
        chk("abort_tz", 32'(bus.total_zeros_o), 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_valid", 32'(bus.out_valid_o), 0);
        end
        return;
      end
    end

    @(negedge clk);
    chk("done_valid", 32'(bus.out_valid_o), 1);
    chk("done_start", 32'(bus.start_cnt_o), 0);
    chk("done_coeff", 32'(bus.coeff_o), 0);
    chk("done_ready", 32'(bus.in_ready_o), 0);
    chk("total_coeff",   32'(bus.total_coeff_o), e_tc);
    chk("trailing_ones", 32'(bus.trailing_ones_o), e_t1);
    chk("t1_signs",      32'(bus.t1_signs_o), e_sg);
    chk("total_zeros",   32'(bus.total_zeros_o), e_tz);

    for (int b = 0; b < bp; b++) begin
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid_o), 1);
      chk("bp_ready", 32'(bus.in_ready_o), 0);
      chk("bp_tc",    32'(bus.total_coeff_o), e_tc);
      chk("bp_t1",    32'(bus.trailing_ones_o), e_t1);
      chk("bp_sg",    32'(bus.t1_signs_o), e_sg);
      chk("bp_tz",    32'(bus.total_zeros_o), e_tz);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk("post_valid", 32'(bus.out_valid_o), 0);
    chk("post_ready", 32'(bus.in_ready_o), 1);
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 16; k++) blk[k] = 8'sd0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, len, ab;
    logic [4:0] bl;
    bus.in_valid_i  = 1'b0;
    bus.coeffs_i    = '0;
    bus.blk_len_i   = 5'd0;
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_tc", 32'(bus.total_coeff_o), 0);
    chk("reset_tz", 32'(bus.total_zeros_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Mixed block with three trailing ones
    clear_blk();
    blk[1] = 8'sd3; blk[2] = -8'sd1; blk[5] = -8'sd1; blk[6] = 8'sd1; blk[8] = 8'sd1;
    run_block(5'd16, 0, -1);

    // All-zero block
    clear_blk();
    run_block(5'd16, 0, -1);

    // Short block; entries beyond L must be ignored
    clear_blk();
    blk[0] = 8'sd2;
    for (int k = 4; k < 16; k++) blk[k] = 8'sd5;
    run_block(5'd4, 0, -1);

    // Sixteen ones, then -128 breaking the trailing-one run
    for (int k = 0; k < 16; k++) blk[k] = 8'sd1;
    run_block(5'd16, 0, -1);
    clear_blk();
    blk[0] = 8'sd1; blk[1] = -8'sd128; blk[2] = -8'sd1;
    run_block(5'd16, 0, -1);

    // Backpressure in DONE
    clear_blk();
    blk[3] = -8'sd1; blk[7] = 8'sd9; blk[10] = 8'sd1;
    run_block(5'd15, 5, -1);

    // Reset mid-scan, then a normal block
    run_block(5'd16, 0, 6);
    run_block(5'd16, 0, -1);

    // Random blocks
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 16; k++) begin
        r = int'($urandom_range(0, 7));
        if (r < 4)       blk[k] = 8'sd0;
        else if (r == 4) blk[k] = 8'sd1;
        else if (r == 5) blk[k] = -8'sd1;
        else if (r == 6) blk[k] = ($urandom_range(0, 1) == 0) ? -8'sd128 : 8'($urandom);
        else             blk[k] = 8'($urandom);
      end
      r = int'($urandom_range(0, 5));
      case (r)
        0: bl = 5'd16;
        1: bl = 5'd15;
        2: bl = 5'd4;
        3: bl = 5'd0;
        4: bl = 5'($urandom_range(17, 31));
        default: bl = 5'($urandom_range(1, 16));
      endcase
      len = (bl == 5'd0 || int'(bl) > 16) ? 16 : int'(bl);
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_block(bl, int'($urandom_range(0, 4)), ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_scan_ctrl.md
Name: cavlc_scan_ctrl

Overview:
Sequencer for one residual block of the CAVLC encoder. It accepts a zigzag-ordered block of coefficients and clears the run-before counter. It then streams the coefficients in reverse scan order (highest frequency first) into the counter's start_cnt_i/coeff_i inputs. In parallel it computes TotalCoeff, TrailingOnes, the trailing-one signs and TotalZeros, and presents them with a valid/ready handshake to the CAVLC bitstream writer.

Parameters:
MAX_LEN, 16, maximum block length; the coefficient bus carries MAX_LEN entries.
CW, 8, coefficient width, signed two's complement.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid_i  input  1  block available
in_ready_o  output  1  controller can accept a block
coeffs_i  input  MAX_LEN*CW  coefficients; entry k (zigzag index k) at bits [k*CW +: CW]
blk_len_i  input  5  block length (16 luma, 15 AC, 4 chroma DC)
cnt_rst_o  output  1  clear pulse to the run-before counter
start_cnt_o  output  1  coefficient strobe to the run-before counter
coeff_o  output  CW  coefficient to the run-before counter
out_valid_o  output  1  statistics valid
out_ready_i  input  1  downstream accepts statistics
total_coeff_o  output  5  nonzero count, 0..16
trailing_ones_o  output  2  trailing ±1 count, 0..3
t1_signs_o  output  3  sign bit per trailing one (1 = negative)
total_zeros_o  output  5  zeros below the highest-frequency nonzero coefficient

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - All state and outputs clear to 0; FSM goes to IDLE.
  - rst overrides every other event, including mid-SCAN and mid-DONE. The partial block is discarded and no out_valid_o is produced for it.
- FSM states: IDLE, CLR, SCAN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i=1, latch coeffs_i and the effective length L, then go to CLR.
  - L = blk_len_i when 1..MAX_LEN; blk_len_i of 0 or above MAX_LEN gives L=MAX_LEN.
- CLR (exactly 1 cycle):
  - cnt_rst_o=1.
  - Statistics registers and the internal first-nonzero flag clear.
  - Scan index idx <= L-1.
  - Go to SCAN.
- SCAN (exactly L cycles):
  - start_cnt_o=1 and coeff_o=coeff[idx], both combinational from state/idx.
  - Each cycle idx decrements; when idx==0, go to DONE.
  - Statistics update on each clock edge, where c=coeff[idx]:
    - if c!=0: total_coeff += 1.
    - if c==0 and a nonzero has already been seen in an earlier SCAN cycle: total_zeros += 1.
    - Trailing-ones tracking is open until the first nonzero with |c|!=1, or until trailing_ones reaches 3.
    - While tracking is open and c==+1 or c==-1: trailing_ones += 1 and t1_signs[trailing_ones] <= sign(c). Bit 0 holds the highest-frequency one.
    - -128 (CW=8) counts as nonzero and is not a one.
  - Coefficients at indices >= L are never driven and never counted.
- DONE:
  - out_valid_o=1; statistics are held stable; in_ready_o=0.
  - On out_ready_i=1, go to IDLE; out_valid_o drops the next cycle.
  - The run-before counter list is final by DONE, because its last update lands on the edge that ends SCAN.
- Outside SCAN: start_cnt_o=0 and coeff_o=0. Outside CLR: cnt_rst_o=0.
- Latency:
  - Input accepted on edge 0; CLR in cycle 1; SCAN in cycles 2..L+1; out_valid_o first high in cycle L+2 (cycle 18 for L=16).
  - Minimum block period is L+3 cycles.
  - in_valid_i is ignored outside IDLE. The next block can be accepted in the cycle after the DONE handshake.
- Widths: 16 nonzeros give total_coeff=16 (5 bits); total_zeros maximum is L-1 (15).

Test Plan:
1. Zigzag block 0,3,-1,0,0,-1,1,0,1,0×7, L=16 -> one cnt_rst pulse, then 16 start_cnt cycles with coeff_o order idx 15..0. Result: total_coeff=5, trailing_ones=3, t1_signs=3'b100, total_zeros=4, out_valid in cycle 18.
2. All-zero block, L=16 -> total_coeff=0, trailing_ones=0, t1_signs=0, total_zeros=0; out_valid still asserted in cycle 18.
3. L=4, block 2,0,0,0 with nonzero entries at indices 4..15 -> only 4 SCAN cycles; total_coeff=1, trailing_ones=0, total_zeros=0; out_valid in cycle 6.
4. All sixteen coefficients =1, then a block 1,-128,-1,0... -> first block: total_coeff=16, trailing_ones=3, t1_signs=0, total_zeros=0. Second block: -128 stops trailing-one counting, giving trailing_ones=1, t1_signs=3'b001, total_coeff=3.
5. Backpressure: out_ready low for 5 cycles in DONE -> out_valid and all statistics stable, in_ready_o=0, in_valid ignored. Accepted one cycle after the handshake.
6. rst asserted in cycle 8 of a scan -> next cycle: IDLE, in_ready_o=1, all outputs 0, no out_valid. A following block completes normally.
